// File: rtl/wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_arbiter_if
// Purpose : bundles the ALU-result, load-result and register-file write
//           signals of the write-back arbiter.
// Signals :
//   alu_valid/alu_ready/alu_rd/alu_data  ALU result handshake
//   mem_valid/mem_ready/mem_rd/mem_data  load result handshake
//   write_enable/addr_rd/data_rd         register-file write port
//   pending_mask                         rd bits with a write still in flight
// Modports: master = producer/consumer side (pipeline, testbench)
//           slave  = the arbiter itself
// ---------------------------------------------------------------------------
interface wb_arbiter_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        write_enable;
  logic [4:0]  addr_rd;
  logic [31:0] data_rd;
  logic [31:0] pending_mask;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready, write_enable, addr_rd, data_rd, pending_mask
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready, write_enable, addr_rd, data_rd, pending_mask
  );
endinterface

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
// Purpose : merges ALU results and load results onto the single register-file
//           write port, at most one write per cycle. ALU results normally win;
//           loads wait in a small FIFO. A starvation counter forces the FIFO
//           head through after STARVE_LIMIT consecutive ALU grants, and an ALU
//           result whose rd matches a queued load is held until that load has
//           drained, so same-rd writes land in program order.
// Ports   :
//   clock  in  rising-edge clock
//   reset  in  synchronous, active-high
//   bus    wb_arbiter_if.slave (ALU/load handshakes, register-file write port,
//          pending_mask)
// Config  : define WB_BYPASS_EN to let a load go straight to the output
//           register when the FIFO is empty and no ALU result is present.
// ---------------------------------------------------------------------------
module wb_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clock,
  input  logic         reset,
  wb_arbiter_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  // FIFO storage (payload is not reset; only the valid bits are)
  logic [4:0]            r_fifo_rd   [FIFO_DEPTH];
  logic [31:0]           r_fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_vld;
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic [SW-1:0]         r_starve;

  // Register-file output stage
  logic                  r_we;
  logic [4:0]            r_addr;
  logic [31:0]           r_data;
  logic [31:0]           r_pend;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_conflict;
  logic                  w_force;
  logic                  w_gnt_fifo;
  logic                  w_gnt_alu;
  logic                  w_gnt_byp;
  logic                  w_mem_ready;
  logic                  w_mem_acc;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_we_nxt;
  logic [4:0]            w_addr_nxt;
  logic [31:0]           w_data_nxt;
  logic [FIFO_DEPTH-1:0] w_vld_nxt;
  logic [31:0]           w_pend_nxt;
  logic [SW-1:0]         w_starve_nxt;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));

  // An ALU result may not overtake an older queued load to the same rd.
  // The FIFO never holds rd 0, so alu_rd==0 can never conflict.
  always_comb begin
    w_conflict = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (r_vld[i] && (r_fifo_rd[i] == bus.alu_rd))
        w_conflict = bus.alu_valid;
    end
  end

  assign w_force     = !w_empty && ((r_starve == SW'(STARVE_LIMIT)) || w_conflict);
  assign w_gnt_fifo  = w_force || (!bus.alu_valid && !w_empty);
  assign w_gnt_alu   = bus.alu_valid && !w_force;
  // Full blocks a push even when the head pops this cycle.
  assign w_mem_ready = !reset && !w_full;
  assign w_mem_acc   = bus.mem_valid && w_mem_ready;

`ifdef WB_BYPASS_EN
  assign w_gnt_byp = w_mem_acc && w_empty && !bus.alu_valid;
`else
  assign w_gnt_byp = 1'b0;
`endif

  assign w_push = w_mem_acc && (bus.mem_rd != 5'd0) && !w_gnt_byp;
  assign w_pop  = w_gnt_fifo;

  assign bus.alu_ready = !reset && w_gnt_alu;
  assign bus.mem_ready = w_mem_ready;

  // Output-register next values; rd 0 results are consumed without a write.
  always_comb begin
    w_we_nxt   = 1'b0;
    w_addr_nxt = r_addr;
    w_data_nxt = r_data;
    if (w_gnt_fifo) begin
      w_we_nxt   = 1'b1;
      w_addr_nxt = r_fifo_rd[r_rd_ptr];
      w_data_nxt = r_fifo_data[r_rd_ptr];
    end else if (w_gnt_alu) begin
      if (bus.alu_rd != 5'd0) begin
        w_we_nxt   = 1'b1;
        w_addr_nxt = bus.alu_rd;
        w_data_nxt = bus.alu_data;
      end
    end else if (w_gnt_byp) begin
      if (bus.mem_rd != 5'd0) begin
        w_we_nxt   = 1'b1;
        w_addr_nxt = bus.mem_rd;
        w_data_nxt = bus.mem_data;
      end
    end
  end

  // The mask is built from the post-update FIFO contents so that it moves in
  // the same cycle as the FIFO and the output register.
  always_comb begin
    w_vld_nxt = r_vld;
    if (w_pop)
      w_vld_nxt[r_rd_ptr] = 1'b0;
    if (w_push)
      w_vld_nxt[r_wr_ptr] = 1'b1;
    w_pend_nxt = 32'd0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (w_vld_nxt[i]) begin
        if (w_push && (i == int'(r_wr_ptr)))
          w_pend_nxt = w_pend_nxt | (32'd1 << bus.mem_rd);
        else
          w_pend_nxt = w_pend_nxt | (32'd1 << r_fifo_rd[i]);
      end
    end
    if (w_we_nxt)
      w_pend_nxt = w_pend_nxt | (32'd1 << w_addr_nxt);
  end

  always_comb begin
    w_starve_nxt = r_starve;
    if (w_gnt_fifo || w_empty)
      w_starve_nxt = '0;
    else if (w_gnt_alu && (r_starve != SW'(STARVE_LIMIT)))
      w_starve_nxt = r_starve + SW'(1);
  end

  // ---- stage boundary: FIFO control, starve counter, output register ----
  always_ff @(posedge clock) begin
    if (reset) begin
      r_vld    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_starve <= '0;
      r_we     <= 1'b0;
      r_addr   <= 5'd0;
      r_data   <= 32'd0;
      r_pend   <= 32'd0;
    end else begin
      r_vld    <= w_vld_nxt;
      r_starve <= w_starve_nxt;
      r_we     <= w_we_nxt;
      r_addr   <= w_addr_nxt;
      r_data   <= w_data_nxt;
      r_pend   <= w_pend_nxt;
      if (w_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO payload: written on push only, no reset needed.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_rd[r_wr_ptr]   <= bus.mem_rd;
      r_fifo_data[r_wr_ptr] <= bus.mem_data;
    end
  end

  assign bus.write_enable = r_we;
  assign bus.addr_rd      = r_addr;
  assign bus.data_rd      = r_data;
  assign bus.pending_mask = r_pend;

endmodule
